// File: rtl/pd_phy_rx_crc_frame.sv
// USB PD PHY receive framer: runs CRC-32 over every decoded byte between
// SOP and EOP, writes header+data (never the trailing 4 CRC bytes) into the
// RX buffer and reports the frame verdict as a one-cycle good/bad pulse.
module pd_phy_rx_crc_frame #(
  parameter int MAX_BYTES = 30,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hard_reset,
  input  logic              receive_enable,
  input  logic              rx_sop,
  input  logic              rx_byte_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_eop,
  input  logic              rx_abort,
  output logic              rxbuf_wr_en,
  output logic [ADDR_W-1:0] rxbuf_wr_addr,
  output logic [7:0]        rxbuf_wr_data,
  output logic [7:0]        rx_header_byte_0,
  output logic [7:0]        rx_header_byte_1,
  output logic [5:0]        rx_byte_count,
  output logic              phy_rx_goodcrc,
  output logic              phy_rx_badcrc,
  output logic              rx_busy
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  // Bytes accepted before the one that overflows the frame (data + 4 CRC).
  localparam logic [5:0]  OVF_AT      = 6'(MAX_BYTES + 4);
  localparam logic [5:0]  MIN_GOOD    = 6'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  // Reflected CRC-32 over one byte, first-on-wire bit (bit 0) first.
  function automatic logic [31:0] crc32_update_byte(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_t      state_r;
  logic [31:0] crc_r;
  logic [7:0]  dly_r [4];
  logic [2:0]  dly_cnt_r;
  logic [5:0]  total_r;
  logic        ovf_r;
  logic        drop_s;

  assign drop_s = rx_abort | hard_reset;

  // Frame FSM: CRC, delay line, buffer writes, header capture and verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      crc_r            <= CRC_INIT;
      for (int i = 0; i < 4; i++) dly_r[i] <= 8'h00;
      dly_cnt_r        <= 3'd0;
      total_r          <= 6'd0;
      ovf_r            <= 1'b0;
      rxbuf_wr_en      <= 1'b0;
      rxbuf_wr_addr    <= '0;
      rxbuf_wr_data    <= 8'h00;
      rx_header_byte_0 <= 8'h00;
      rx_header_byte_1 <= 8'h00;
      rx_byte_count    <= 6'd0;
      phy_rx_goodcrc   <= 1'b0;
      phy_rx_badcrc    <= 1'b0;
      rx_busy          <= 1'b0;
    end else begin
      rxbuf_wr_en    <= 1'b0;
      phy_rx_goodcrc <= 1'b0;
      phy_rx_badcrc  <= 1'b0;
      if (drop_s) begin
        // Abort: leave quietly, already-written bytes are simply stale.
        state_r <= ST_IDLE;
        rx_busy <= 1'b0;
      end else if (rx_sop && (state_r != ST_CHECK)) begin
        if (receive_enable) begin
          state_r          <= ST_RECV;
          rx_busy          <= 1'b1;
          crc_r            <= CRC_INIT;
          dly_cnt_r        <= 3'd0;
          total_r          <= 6'd0;
          ovf_r            <= 1'b0;
          rxbuf_wr_addr    <= '0;
          rx_header_byte_0 <= 8'h00;
          rx_header_byte_1 <= 8'h00;
          rx_byte_count    <= 6'd0;
        end else begin
          state_r <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
            rx_busy <= 1'b0;
          end
          ST_RECV: begin
            if (rx_byte_valid && (total_r == OVF_AT)) begin
              // Frame too long: freeze CRC, verdict will be forced bad.
              ovf_r   <= 1'b1;
              state_r <= rx_eop ? ST_CHECK : ST_DISCARD;
            end else begin
              if (rx_byte_valid) begin
                crc_r    <= crc32_update_byte(crc_r, rx_byte);
                dly_r[0] <= rx_byte;
                dly_r[1] <= dly_r[0];
                dly_r[2] <= dly_r[1];
                dly_r[3] <= dly_r[2];
                total_r  <= total_r + 6'd1;
                if (total_r == 6'd0) begin
                  rx_header_byte_0 <= rx_byte;
                end else if (total_r == 6'd1) begin
                  rx_header_byte_1 <= rx_byte;
                end else begin
                  rx_header_byte_1 <= rx_header_byte_1;
                end
                if (dly_cnt_r == 3'd4) begin
                  // Oldest byte is proven not to be CRC: commit it.
                  rxbuf_wr_en   <= 1'b1;
                  rxbuf_wr_addr <= rx_byte_count[ADDR_W-1:0];
                  rxbuf_wr_data <= dly_r[3];
                  rx_byte_count <= rx_byte_count + 6'd1;
                end else begin
                  dly_cnt_r <= dly_cnt_r + 3'd1;
                end
              end
              if (rx_eop) begin
                state_r <= ST_CHECK;
              end
            end
          end
          ST_DISCARD: begin
            if (rx_eop) begin
              state_r <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (!ovf_r && (crc_r == CRC_RESIDUE) && (total_r >= MIN_GOOD)) begin
              phy_rx_goodcrc <= 1'b1;
            end else begin
              phy_rx_badcrc <= 1'b1;
            end
            state_r <= ST_IDLE;
            rx_busy <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pd_phy_rx_crc_frame.sv
// Self-checking bench for pd_phy_rx_crc_frame: directed frames from the test
// plan plus randomized frames judged by a frame-level reference model.
module tb_pd_phy_rx_crc_frame;

  localparam int MAX_BYTES = 30;
  localparam int ADDR_W    = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              hard_reset = 1'b0;
  logic              receive_enable = 1'b0;
  logic              rx_sop = 1'b0;
  logic              rx_byte_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_eop = 1'b0;
  logic              rx_abort = 1'b0;
  logic              rxbuf_wr_en;
  logic [ADDR_W-1:0] rxbuf_wr_addr;
  logic [7:0]        rxbuf_wr_data;
  logic [7:0]        rx_header_byte_0;
  logic [7:0]        rx_header_byte_1;
  logic [5:0]        rx_byte_count;
  logic              phy_rx_goodcrc;
  logic              phy_rx_badcrc;
  logic              rx_busy;

  pd_phy_rx_crc_frame #(.MAX_BYTES(MAX_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .hard_reset(hard_reset),
    .receive_enable(receive_enable), .rx_sop(rx_sop),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_eop(rx_eop),
    .rx_abort(rx_abort), .rxbuf_wr_en(rxbuf_wr_en),
    .rxbuf_wr_addr(rxbuf_wr_addr), .rxbuf_wr_data(rxbuf_wr_data),
    .rx_header_byte_0(rx_header_byte_0), .rx_header_byte_1(rx_header_byte_1),
    .rx_byte_count(rx_byte_count), .phy_rx_goodcrc(phy_rx_goodcrc),
    .phy_rx_badcrc(phy_rx_badcrc), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] frm_q[$];
  int wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int good_n = 0, bad_n = 0, busy_n = 0, pulse_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rxbuf_wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(rxbuf_wr_addr));
      wr_data_q.push_back(rxbuf_wr_data);
    end
    if (phy_rx_goodcrc === 1'b1) begin good_n++; pulse_cyc = cyc; end
    if (phy_rx_badcrc === 1'b1) begin bad_n++; pulse_cyc = cyc; end
    if (rx_busy === 1'b1) busy_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard USB PD / IEEE CRC-32 of the first n bytes of the frame.
  function automatic logic [31:0] crc32_ref(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic append_crc(input bit corrupt);
    logic [31:0] c;
    c = crc32_ref(frm_q.size());
    if (corrupt) c = c ^ (32'h1 << $urandom_range(31, 0));
    frm_q.push_back(c[7:0]);
    frm_q.push_back(c[15:8]);
    frm_q.push_back(c[23:16]);
    frm_q.push_back(c[31:24]);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    wr_addr_q.delete();
    wr_data_q.delete();
    good_n = 0; bad_n = 0; busy_n = 0; pulse_cyc = -1;
  endtask

  // Drive SOP, the bytes of frm_q (optional idle gaps), then EOP.
  task automatic run_frame(input bit en, input bit gaps, input bit eop_sep,
                           output int eop_cyc);
    int n = frm_q.size();
    eop_cyc = -1;
    @(negedge clk); rx_sop = 1'b1; receive_enable = en;
    @(negedge clk); rx_sop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(3, 0) == 0)) begin
        rx_byte_valid = 1'b0;
        @(negedge clk);
      end
      rx_byte_valid = 1'b1;
      rx_byte = frm_q[i];
      rx_eop = (!eop_sep && (i == n - 1));
      if (rx_eop) eop_cyc = cyc;
      @(negedge clk);
    end
    rx_byte_valid = 1'b0;
    rx_eop = 1'b0;
    if (eop_sep || n == 0) begin
      rx_eop = 1'b1;
      eop_cyc = cyc;
      @(negedge clk);
      rx_eop = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Frame-level expectations: writes, header, count, verdict, pulse timing.
  task automatic check_frame(input string tag, input bit en, input int eop_cyc);
    int n = frm_q.size();
    int nw;
    bit good;
    if (!en) begin
      chk({tag, "_writes"}, wr_addr_q.size(), 0);
      chk({tag, "_pulses"}, good_n + bad_n, 0);
      chk({tag, "_busy"}, busy_n, 0);
      return;
    end
    nw = (n > 4) ? ((n - 4 > MAX_BYTES) ? MAX_BYTES : n - 4) : 0;
    good = (n < MAX_BYTES + 5) && (n >= 6) &&
           (crc32_ref(n - 4) == {frm_q[n-1], frm_q[n-2], frm_q[n-3], frm_q[n-4]});
    chk({tag, "_nwrites"}, wr_addr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      chk({tag, "_addr"}, wr_addr_q[i], i);
      chk({tag, "_data"}, wr_data_q[i], frm_q[i]);
    end
    chk({tag, "_hdr0"}, rx_header_byte_0, (n >= 1) ? frm_q[0] : 8'h00);
    chk({tag, "_hdr1"}, rx_header_byte_1, (n >= 2) ? frm_q[1] : 8'h00);
    chk({tag, "_count"}, rx_byte_count, nw);
    chk({tag, "_good"}, good_n, good ? 1 : 0);
    chk({tag, "_bad"}, bad_n, good ? 0 : 1);
    chk({tag, "_pulse_cyc"}, pulse_cyc, eop_cyc + 2);
    chk({tag, "_idle"}, rx_busy, 1'b0);
  endtask

  task automatic load_good9(input bit bad_last);
    frm_q.delete();
    for (int i = 0; i < 9; i++) frm_q.push_back(8'h31 + 8'(i));
    frm_q.push_back(8'h26); frm_q.push_back(8'h39);
    frm_q.push_back(8'hF4); frm_q.push_back(bad_last ? 8'hCA : 8'hCB);
  endtask

  initial begin
    int ec;
    int plen;
    // Reset state.
    #12;
    chk("rst_wr_en", rxbuf_wr_en, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_pulses", {phy_rx_goodcrc, phy_rx_badcrc}, 2'b00);
    chk("rst_count", rx_byte_count, 6'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good CRC frame ("123456789" + CRC).
    load_good9(1'b0);
    clear_mon(); run_frame(1'b1, 1'b0, 1'b0, ec);
    chk("good9_is_good", good_n, 1);
    check_frame("good9", 1'b1, ec);

    // Bad CRC frame.
    load_good9(1'b1);
    clear_mon(); run_frame(1'b1, 1'b0, 1'b1, ec);
    chk("bad9_is_bad", bad_n, 1);
    check_frame("bad9", 1'b1, ec);

    // Short frame.
    frm_q = '{8'h41, 8'h00, 8'h12};
    clear_mon(); run_frame(1'b1, 1'b0, 1'b0, ec);
    check_frame("short", 1'b1, ec);

    // Overflow: 40 zero bytes.
    frm_q.delete();
    for (int i = 0; i < 40; i++) frm_q.push_back(8'h00);
    clear_mon(); run_frame(1'b1, 1'b0, 1'b0, ec);
    check_frame("ovf", 1'b1, ec);

    // Boundary: 2-byte payload with valid CRC (6 total) is good; 1-byte is not.
    frm_q = '{8'hA5, 8'h5A}; append_crc(1'b0);
    clear_mon(); run_frame(1'b1, 1'b0, 1'b0, ec);
    chk("min6_is_good", good_n, 1);
    check_frame("min6", 1'b1, ec);
    frm_q = '{8'hA5}; append_crc(1'b0);
    clear_mon(); run_frame(1'b1, 1'b0, 1'b0, ec);
    check_frame("len5", 1'b1, ec);

    // Boundary: largest payload that fits, then one byte more.
    frm_q.delete();
    for (int i = 0; i < MAX_BYTES; i++) frm_q.push_back(8'($urandom));
    append_crc(1'b0);
    clear_mon(); run_frame(1'b1, 1'b1, 1'b0, ec);
    chk("max_is_good", good_n, 1);
    check_frame("max", 1'b1, ec);
    frm_q.delete();
    for (int i = 0; i < MAX_BYTES + 1; i++) frm_q.push_back(8'($urandom));
    append_crc(1'b0);
    clear_mon(); run_frame(1'b1, 1'b0, 1'b1, ec);
    check_frame("max_plus1", 1'b1, ec);

    // Gating: receive_enable low at SOP.
    load_good9(1'b0);
    clear_mon(); run_frame(1'b0, 1'b0, 1'b0, ec);
    check_frame("gated", 1'b0, ec);

    // Hard reset after 5 bytes: no pulse, back to idle, later bytes ignored.
    clear_mon();
    @(negedge clk); rx_sop = 1'b1; receive_enable = 1'b1;
    @(negedge clk); rx_sop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_byte_valid = 1'b1; rx_byte = 8'h60 + 8'(i);
      @(negedge clk);
    end
    rx_byte_valid = 1'b0; hard_reset = 1'b1;
    @(negedge clk); hard_reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("hrst_busy", rx_busy, 1'b0);
    chk("hrst_pulses", good_n + bad_n, 0);
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rx_byte_valid = 1'b1; rx_byte = 8'(i);
    end
    rx_eop = 1'b1;
    @(negedge clk); rx_byte_valid = 1'b0; rx_eop = 1'b0;
    repeat (4) @(negedge clk);
    chk("nosop_writes", wr_addr_q.size(), 0);
    chk("nosop_pulses", good_n + bad_n, 0);

    // Async reset mid-frame, 3 ns wide, between clock edges.
    load_good9(1'b0);
    clear_mon();
    @(negedge clk); rx_sop = 1'b1; receive_enable = 1'b1;
    @(negedge clk); rx_sop = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rx_byte_valid = 1'b1; rx_byte = frm_q[i];
      @(negedge clk);
    end
    rx_byte_valid = 1'b0;
    chk("arst_pre_busy", rx_busy, 1'b1);
    chk("arst_pre_wr_en", rxbuf_wr_en, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", rx_busy, 1'b0);
    chk("arst_wr_en", rxbuf_wr_en, 1'b0);
    chk("arst_hdr", {rx_header_byte_0, rx_header_byte_1}, 16'h0000);
    chk("arst_count", rx_byte_count, 6'd0);
    chk("arst_addr_data", {rxbuf_wr_addr, rxbuf_wr_data}, 13'd0);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon(); run_frame(1'b1, 1'b0, 1'b0, ec);
    chk("post_arst_good", good_n, 1);
    check_frame("post_arst", 1'b1, ec);

    // Randomized frames against the frame-level model.
    for (int f = 0; f < 16; f++) begin
      frm_q.delete();
      plen = $urandom_range(MAX_BYTES + 2, 0);
      for (int i = 0; i < plen; i++) frm_q.push_back(8'($urandom));
      if ($urandom_range(4, 0) != 0) append_crc($urandom_range(3, 0) == 0);
      clear_mon();
      run_frame(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ec);
      check_frame($sformatf("rand%0d", f), 1'b1, ec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
